// File: rtl/detc_rate_adapter.sv
// Re-times one extracted displacement per video frame into one strobe (60Hz pass) or four strobes (240Hz split).
// Optional frame timeout (TimeoutCount/Timeout ports) is built when FRAME_TIMEOUT_EN is defined.
module detc_rate_adapter #(
    parameter int DETC_DATA_WIDTH = 13,
    parameter int PERIOD_WIDTH    = 32
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic                              DetcValid,
    input  logic signed [DETC_DATA_WIDTH-1:0] DetcData,
    input  logic                              En240Hz,
`ifdef FRAME_TIMEOUT_EN
    input  logic [PERIOD_WIDTH-1:0]           TimeoutCount,
    output logic                              Timeout,
`endif
    output logic                              ExtractFlag,
    output logic signed [DETC_DATA_WIDTH-1:0] OutDetcData,
    output logic                              OutEn240Hz,
    output logic                              PeriodValid,
    output logic                              Overrun
);
    localparam int W = DETC_DATA_WIDTH;
    localparam int P = PERIOD_WIDTH;
    localparam logic [P-1:0]        P_ONE   = {{(P-1){1'b0}}, 1'b1};
    localparam logic [P-1:0]        P_MAX   = {P{1'b1}};
    localparam logic signed [W+1:0] SAT_MAX = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] SAT_MIN = {3'b111, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, SPLIT = 2'd2} state_t;

    state_t            state_r;
    logic [P-1:0]      cnt_r;
    logic [P-1:0]      period_r;
    logic [P-1:0]      tmr_r;
    logic              seen_first_r;
    logic [W:0]        mag_q_r;
    logic [1:0]        mag_r_r;
    logic [1:0]        k_r;
    logic              neg_r;
    logic signed [W:0] rem_r;

    logic signed [W:0]   ext_s;
    logic [W:0]          abs_s;
    logic signed [W:0]   new_v0_s;
    logic signed [W:0]   cur_v_s;
    logic signed [W:0]   carry_s;
    logic signed [W:0]   base_s;
    logic signed [W+1:0] sum_s;
    logic signed [W-1:0] first_s;
    logic                split_s;
    logic [P-1:0]        new_step_s;
    logic [P-1:0]        step_s;

    // Strobe k of a split: |q| plus one extra unit for the first |r| strobes, sign restored.
    function automatic logic signed [W:0] split_val(input logic [W:0] mag_q, input logic [1:0] mag_r,
                                                    input logic neg, input logic [1:0] k);
        logic [W:0] m;
        if (k < mag_r) m = mag_q + {{W{1'b0}}, 1'b1};
        else           m = mag_q;
        if (neg) split_val = -$signed(m);
        else     split_val = $signed(m);
    endfunction

    function automatic logic [P-1:0] step_of(input logic [P-1:0] period);
        if (period[P-1:2] == {(P-2){1'b0}}) step_of = P_ONE;
        else                                step_of = period >> 2;
    endfunction

    function automatic logic signed [W-1:0] sat(input logic signed [W+1:0] x);
        if (x > SAT_MAX)      sat = SAT_MAX[W-1:0];
        else if (x < SAT_MIN) sat = SAT_MIN[W-1:0];
        else                  sat = x[W-1:0];
    endfunction

    // Decode the incoming sample and form the first strobe of a new frame, including any carried-over sum.
    always_comb begin
        ext_s = {DetcData[W-1], DetcData};
        if (DetcData[W-1]) abs_s = $unsigned(-ext_s);
        else               abs_s = $unsigned(ext_s);
        split_s    = En240Hz & PeriodValid;
        new_step_s = step_of(cnt_r);
        step_s     = step_of(period_r);
        new_v0_s   = split_val(abs_s >> 2, abs_s[1:0], DetcData[W-1], 2'd0);
        cur_v_s    = split_val(mag_q_r, mag_r_r, neg_r, k_r);
        if (state_r == SPLIT) carry_s = rem_r;
        else                  carry_s = {(W+1){1'b0}};
        if (split_s) base_s = new_v0_s;
        else         base_s = ext_s;
        sum_s   = {base_s[W], base_s} + {carry_s[W], carry_s};
        first_s = sat(sum_s);
    end

    // Period measurement, frame FSM and all registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r      <= IDLE;
            cnt_r        <= {P{1'b0}};
            period_r     <= {P{1'b0}};
            tmr_r        <= {P{1'b0}};
            seen_first_r <= 1'b0;
            mag_q_r      <= {(W+1){1'b0}};
            mag_r_r      <= 2'd0;
            k_r          <= 2'd0;
            neg_r        <= 1'b0;
            rem_r        <= {(W+1){1'b0}};
            ExtractFlag  <= 1'b0;
            OutDetcData  <= {W{1'b0}};
            OutEn240Hz   <= 1'b0;
            PeriodValid  <= 1'b0;
            Overrun      <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
            Timeout      <= 1'b0;
`endif
        end else begin
            ExtractFlag <= 1'b0;
            Overrun     <= 1'b0;
            if (DetcValid) begin
                cnt_r        <= P_ONE;
                period_r     <= cnt_r;
                seen_first_r <= 1'b1;
                if (seen_first_r) PeriodValid <= 1'b1;
                else              PeriodValid <= PeriodValid;
                OutEn240Hz  <= En240Hz;
                ExtractFlag <= 1'b1;
                Overrun     <= (state_r == SPLIT);
                OutDetcData <= first_s;
`ifdef FRAME_TIMEOUT_EN
                Timeout     <= 1'b0;
`endif
                if (split_s) begin
                    state_r <= SPLIT;
                    mag_q_r <= abs_s >> 2;
                    mag_r_r <= abs_s[1:0];
                    neg_r   <= DetcData[W-1];
                    k_r     <= 2'd1;
                    tmr_r   <= new_step_s;
                    rem_r   <= ext_s - new_v0_s;
                end else begin
                    state_r <= PASS;
                end
            end else begin
                if (cnt_r != P_MAX) cnt_r <= cnt_r + P_ONE;
                else                cnt_r <= cnt_r;
`ifdef FRAME_TIMEOUT_EN
                // A missing frame invalidates the period so the next frame falls back to pass.
                if (TimeoutCount != {P{1'b0}} && cnt_r == TimeoutCount) begin
                    Timeout      <= 1'b1;
                    PeriodValid  <= 1'b0;
                    seen_first_r <= 1'b0;
                end else begin
                    Timeout <= Timeout;
                end
`endif
                case (state_r)
                    IDLE: state_r <= IDLE;
                    PASS: state_r <= IDLE;
                    SPLIT: begin
                        if (tmr_r == P_ONE) begin
                            ExtractFlag <= 1'b1;
                            OutDetcData <= cur_v_s[W-1:0];
                            rem_r       <= rem_r - cur_v_s;
                            tmr_r       <= step_s;
                            k_r         <= k_r + 2'd1;
                            if (k_r == 2'd3) state_r <= IDLE;
                            else             state_r <= SPLIT;
                        end else begin
                            tmr_r <= tmr_r - P_ONE;
                        end
                    end
                    default: state_r <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_detc_rate_adapter.sv
// Directed bench for detc_rate_adapter: a cycle-indexed strobe schedule model plus literal pins.
`timescale 1ns/1ps
module tb_detc_rate_adapter;
    localparam int W    = 13;
    localparam int MAXV = 4095;
    localparam int MINV = -4096;

    logic                clk = 1'b0;
    logic                n_rst = 1'b1;
    logic                DetcValid = 1'b0;
    logic signed [W-1:0] DetcData = 13'sd0;
    logic                En240Hz = 1'b0;
    logic                ExtractFlag;
    logic signed [W-1:0] OutDetcData;
    logic                OutEn240Hz;
    logic                PeriodValid;
    logic                Overrun;
`ifdef FRAME_TIMEOUT_EN
    logic [31:0]         tc = 32'd0;
    logic                Timeout;
    bit                  to_old, to_new;
    int                  to_eff;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model: expected strobe value and overrun flag by the cycle they are visible.
    int  sched[int];
    bit  sched_ovr[int];
    int  last_data, last_c, frames, pv_eff, en_eff;
    bit  have_last, pv_old, pv_new, en_old, en_new;

    detc_rate_adapter #(.DETC_DATA_WIDTH(W), .PERIOD_WIDTH(32)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .DetcValid(DetcValid),
        .DetcData(DetcData),
        .En240Hz(En240Hz),
`ifdef FRAME_TIMEOUT_EN
        .TimeoutCount(tc),
        .Timeout(Timeout),
`endif
        .ExtractFlag(ExtractFlag),
        .OutDetcData(OutDetcData),
        .OutEn240Hz(OutEn240Hz),
        .PeriodValid(PeriodValid),
        .Overrun(Overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int sat(input int x);
        if (x > MAXV)      return MAXV;
        else if (x < MINV) return MINV;
        else               return x;
    endfunction

    task automatic model_reset();
        sched.delete();
        sched_ovr.delete();
        last_data = 0; last_c = 0; frames = 0; have_last = 1'b0;
        pv_old = 1'b0; pv_new = 1'b0; pv_eff = 0;
        en_old = 1'b0; en_new = 1'b0; en_eff = 0;
`ifdef FRAME_TIMEOUT_EN
        to_old = 1'b0; to_new = 1'b0; to_eff = 0;
`endif
    endtask

    // A frame at cycle c: strobes still to be seen after c are withdrawn and folded into strobe 0.
    task automatic model_frame(input int c, input int d, input bit en);
        int u, step, q, r, ar, s, v;
        bit ovr, pv;
        int keys[$];
        pv  = (c >= pv_eff) ? pv_new : pv_old;
        u   = 0;
        ovr = 1'b0;
        foreach (sched[key]) if (key > c) keys.push_back(key);
        foreach (keys[i]) begin
            u += sched[keys[i]];
            ovr = 1'b1;
            sched.delete(keys[i]);
            sched_ovr.delete(keys[i]);
        end
        if (en && pv) begin
            step = (c - last_c) / 4;
            if (step < 1) step = 1;
            q  = d / 4;
            r  = d - 4 * q;
            ar = (r < 0) ? -r : r;
            s  = (d > 0) ? 1 : ((d < 0) ? -1 : 0);
            for (int k = 0; k < 4; k++) begin
                v = q + ((k < ar) ? s : 0);
                if (k == 0) v = sat(v + u);
                sched[c + 1 + k * step]     = v;
                sched_ovr[c + 1 + k * step] = 1'b0;
            end
        end else begin
            sched[c + 1] = sat(d + u);
        end
        sched_ovr[c + 1] = ovr;
        pv_old = pv;
        pv_new = pv || (frames >= 1);
        pv_eff = c + 1;
        frames++;
        en_old = (c >= en_eff) ? en_new : en_old;
        en_new = en;
        en_eff = c + 1;
`ifdef FRAME_TIMEOUT_EN
        to_old = (c >= to_eff) ? to_new : to_old;
        to_new = 1'b0;
        to_eff = c + 1;
`endif
        last_c    = c;
        have_last = 1'b1;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        bit f;
        bit o;
        if (n_rst) begin
`ifdef FRAME_TIMEOUT_EN
            if (tc != 32'd0 && have_last && cyc == last_c + int'(tc) + 1) begin
                pv_old = 1'b0; pv_new = 1'b0; frames = 0; to_old = 1'b1; to_new = 1'b1;
            end
            chk("timeout", Timeout, (cyc >= to_eff) ? to_new : to_old);
`endif
            f = sched.exists(cyc) ? 1'b1 : 1'b0;
            o = 1'b0;
            if (f) begin
                last_data = sched[cyc];
                o = sched_ovr[cyc];
            end
            chk("extract_flag", ExtractFlag, f);
            chk("out_data", OutDetcData, last_data);
            chk("overrun", Overrun, o);
            chk("period_valid", PeriodValid, (cyc >= pv_eff) ? pv_new : pv_old);
            chk("out_en240", OutEn240Hz, (cyc >= en_eff) ? en_new : en_old);
        end
    end

    task automatic go_to(input int c);
        chk("schedule_order", (cyc <= c) ? 1 : 0, 1);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input int c, input int d, input bit en);
        go_to(c);
        DetcValid = 1'b1;
        DetcData  = d[W-1:0];
        En240Hz   = en;
        model_frame(cyc, d, en);
        @(posedge clk);
        #1;
        DetcValid = 1'b0;
    endtask

    task automatic pin(input int c, input int val, input int ovr);
        go_to(c);
        @(negedge clk);
        chk("pin_flag", ExtractFlag, 1);
        chk("pin_data", OutDetcData, val);
        chk("pin_overrun", Overrun, ovr);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_flag"}, ExtractFlag, 0);
        chk({tag, "_data"}, OutDetcData, 0);
        chk({tag, "_period_valid"}, PeriodValid, 0);
        chk({tag, "_en240"}, OutEn240Hz, 0);
        chk({tag, "_overrun"}, Overrun, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        model_reset();
        #2 n_rst = 1'b0;
        #1 reset_checks("reset");
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;

        // Pass mode, then the second frame arms the period (still pass).
        frame(10, -100, 1'b0);
        pin(11, -100, 0);
        chk("pass_en240", OutEn240Hz, 0);
        frame(410, 0, 1'b1);
        pin(411, 0, 0);
        chk("pv_after_second", PeriodValid, 1);

        // Split with period 400: step 100.
        frame(810, 7, 1'b1);
        pin(811, 2, 0);  pin(911, 2, 0);  pin(1011, 2, 0);  pin(1111, 1, 0);
        frame(1210, -6, 1'b1);
        pin(1211, -2, 0); pin(1311, -2, 0); pin(1411, -1, 0); pin(1511, -1, 0);

        // Overrun after two strobes: carry 4 into the new frame, new step 37.
        frame(1610, 8, 1'b1);
        pin(1711, 2, 0);
        frame(1760, 4, 1'b1);
        pin(1761, 5, 1);
        pin(1798, 1, 0); pin(1872, 1, 0);

        // Back-to-back frames: step 1 split, carried sum lands at the limit.
        frame(2160, 4095, 1'b1);
        pin(2161, 1024, 0);
        frame(2161, 4095, 1'b1);
        pin(2162, 4095, 1);
        pin(2163, 1024, 0); pin(2165, 1023, 0);

        // Carry into a pass frame that clips at both ends of the range.
        frame(2565, 4095, 1'b1);
        pin(2667, 1024, 0);
        frame(2700, 4095, 1'b0);
        pin(2701, 4095, 1);
        frame(3100, -4096, 1'b1);
        pin(3201, -1024, 0);
        frame(3250, -4096, 1'b0);
        pin(3251, -4096, 1);

        // New frame on the same edge as a scheduled strobe: that strobe is carried.
        frame(3650, 8, 1'b1);
        pin(3751, 2, 0);
        frame(3850, 0, 1'b1);
        pin(3851, 4, 1);
        pin(3901, 0, 0);

        // Reset in the middle of a split drops the pending strobes.
        frame(4400, 7, 1'b1);
        pin(4401, 2, 0);
        go_to(4450);
        n_rst = 1'b0;
        model_reset();
        #1 reset_checks("mid_reset");
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        frame(4600, 5, 1'b1);
        pin(4601, 5, 0);
        frame(4700, 9, 1'b1);
        pin(4701, 9, 0);
        go_to(4800);
        chk("pv_after_reset_rearm", PeriodValid, 1);

`ifdef FRAME_TIMEOUT_EN
        tc = 32'd1000;
        go_to(5706);
        @(negedge clk);
        chk("timeout_set", Timeout, 1);
        chk("timeout_pv", PeriodValid, 0);
        frame(5710, 3, 1'b1);
        pin(5711, 3, 0);
        go_to(5900);
        chk("timeout_cleared", Timeout, 0);
`endif

        go_to(cyc + 5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
